alu_seq: RTL and testbench

- Arithmetic/logic unit on the operand side of the accumulator datapath of the 16-bit CPU.
- Decodes the same 32-bit control_signal micro-op word the accumulator decodes, and produces to_ACC, the value the accumulator captures.
- Single-cycle ops are combinational. Multiply and divide are multi-cycle, with a busy/done handshake to the control unit, and their high half is held in a buffer register (BR).

---
 rtl/alu_pkg.sv | 30 +++
 rtl/mul_div_core.sv | 145 ++++++++++++++
 rtl/alu_seq.sv | 103 ++++++++++
 tb/tb_alu_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the accumulator-side ALU: micro-op bit positions,
// multiply/divide sequencer state encodings and flag bit positions.
package alu_pkg;

    // Micro-op bit positions within control_signal
    localparam int OP_ADD = 9;
    localparam int OP_DIV = 10;
    localparam int OP_SUB = 11;
    localparam int OP_AND = 12;
    localparam int OP_MPY = 13;
    localparam int OP_OR  = 14;
    localparam int OP_NOT = 15;
    localparam int OP_SHR = 16;
    localparam int OP_SHL = 17;
    localparam int OP_MOV = 18;

    // Sequencer states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_DIV  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // Flag bit positions inside the 4-bit {Z,N,C,V} vector
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/mul_div_core.sv
// Multi-cycle unsigned multiply / restoring divide sequencer.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a start; MPY has priority over DIV
// MUL     | one shift-add iteration per cycle, WIDTH cycles
// DIV     | one restoring-divide iteration per cycle, WIDTH cycles
// DONE    | single cycle, done=1; result_lo/BR were loaded on entry
//
// Multiply keeps the partial product in acc_q and shifts it right each
// step, so the multiplicand never needs a wide shifter. Divide keeps
// {remainder, dividend/quotient} in acc_q and shifts left each step.
module mul_div_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_mpy_i,
    input  logic             start_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_lo_o,
    output logic [WIDTH-1:0] br_o,
    output logic             dz_o
);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     br_q, br_d;
    logic                 dz_q, dz_d;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_rem;
    logic [WIDTH:0]       div_diff;
    logic                 last_iter;

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state and datapath update for the sequencer
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        lo_d     = lo_q;
        br_d     = br_q;
        dz_d     = dz_q;
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
        div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = div_rem - {1'b0, b_q};

        case (state_q)
            ST_IDLE: begin
                if (start_mpy_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    dz_d    = 1'b0;
                    state_d = ST_MUL;
                end else if (start_div_i) begin
                    if (b_i == '0) begin
                        // No iterations: saturated quotient, dividend as remainder
                        lo_d    = '1;
                        br_d    = a_i;
                        dz_d    = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        b_d     = b_i;
                        acc_d   = {{WIDTH{1'b0}}, a_i};
                        cnt_d   = '0;
                        dz_d    = 1'b0;
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    lo_d    = acc_d[WIDTH-1:0];
                    br_d    = acc_d[2*WIDTH-1:WIDTH];
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                if (!div_diff[WIDTH]) begin
                    acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    lo_d    = acc_d[WIDTH-1:0];
                    br_d    = acc_d[2*WIDTH-1:WIDTH];
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset aborts any operation and clears results
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            lo_q    <= '0;
            br_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            lo_q    <= lo_d;
            br_q    <= br_d;
            dz_q    <= dz_d;
        end
    end

    assign busy_o      = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign done_o      = (state_q == ST_DONE);
    assign result_lo_o = lo_q;
    assign br_o        = br_q;
    assign dz_o        = dz_q;

endmodule

// File: rtl/alu_seq.sv
// Operand-side ALU of the accumulator datapath: combinational op mux
// feeding to_ACC, the ADD/SUB flag register, and the multi-cycle
// multiply/divide sequencer.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      control_signal,
    input  logic [WIDTH-1:0] from_ACC,
    input  logic [WIDTH-1:0] from_MBR,
    output logic [WIDTH-1:0] to_ACC,
    output logic [WIDTH-1:0] BR_out,
    output logic             busy,
    output logic             done,
    output logic [3:0]       flags,
    output logic             dz
);

    logic [WIDTH-1:0] result_lo;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] arith_r;
    logic [3:0]       flags_q, flags_d;
    logic             flag_upd;
    logic             ctrl_unused;

    // Bits outside the decoded set; bit 8 is the accumulator's own clear
    assign ctrl_unused = ^{control_signal[31:19], control_signal[8:0]};

    mul_div_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .start_mpy_i (control_signal[OP_MPY]),
        .start_div_i (control_signal[OP_DIV]),
        .a_i         (from_ACC),
        .b_i         (from_MBR),
        .busy_o      (busy),
        .done_o      (done),
        .result_lo_o (result_lo),
        .br_o        (BR_out),
        .dz_o        (dz)
    );

    assign add_s = {1'b0, from_ACC} + {1'b0, from_MBR};
    assign sub_s = {1'b0, from_ACC} - {1'b0, from_MBR};

    // Result mux in accumulator priority order; forced to zero while busy
    always_comb begin
        res = '0;
        if (!busy) begin
            if (control_signal[OP_ADD])      res = add_s[WIDTH-1:0];
            else if (control_signal[OP_MOV]) res = result_lo;
            else if (control_signal[OP_SHL]) res = {from_ACC[WIDTH-2:0], 1'b0};
            else if (control_signal[OP_SHR]) res = {from_ACC[WIDTH-1], from_ACC[WIDTH-1:1]};
            else if (control_signal[OP_NOT]) res = ~from_ACC;
            else if (control_signal[OP_OR])  res = from_ACC | from_MBR;
            else if (control_signal[OP_AND]) res = from_ACC & from_MBR;
            else if (control_signal[OP_SUB]) res = sub_s[WIDTH-1:0];
        end
    end

    assign to_ACC = res;

    // Flags for the winning arithmetic op (ADD outranks SUB)
    always_comb begin
        flags_d = '0;
        if (control_signal[OP_ADD]) begin
            arith_r         = add_s[WIDTH-1:0];
            flags_d[FLAG_C] = add_s[WIDTH];
            flags_d[FLAG_V] = (from_ACC[WIDTH-1] == from_MBR[WIDTH-1]) &&
                              (arith_r[WIDTH-1] != from_ACC[WIDTH-1]);
        end else begin
            arith_r         = sub_s[WIDTH-1:0];
            flags_d[FLAG_C] = sub_s[WIDTH];
            flags_d[FLAG_V] = (from_ACC[WIDTH-1] != from_MBR[WIDTH-1]) &&
                              (arith_r[WIDTH-1] != from_ACC[WIDTH-1]);
        end
        flags_d[FLAG_Z] = (arith_r == '0);
        flags_d[FLAG_N] = arith_r[WIDTH-1];
    end

    assign flag_upd = (control_signal[OP_ADD] || control_signal[OP_SUB]) && !busy;

    // Flag register, loaded only by an ADD/SUB outside a multi-cycle op
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (flag_upd) begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expectations, a negedge
// monitor pops and compares them, and matches every done pulse against
// a queue of expected multiply/divide completions.
module tb_alu_seq;

    localparam int B_ADD = 9;
    localparam int B_DIV = 10;
    localparam int B_SUB = 11;
    localparam int B_AND = 12;
    localparam int B_MPY = 13;
    localparam int B_OR  = 14;
    localparam int B_NOT = 15;
    localparam int B_SHR = 16;
    localparam int B_SHL = 17;
    localparam int B_MOV = 18;

    localparam int K_ACC   = 0;
    localparam int K_BR    = 1;
    localparam int K_FLAGS = 2;
    localparam int K_DZ    = 3;
    localparam int K_BUSY  = 4;
    localparam int K_DONE  = 5;

    typedef struct {
        string       name;
        int          kind;
        logic [15:0] val;
    } exp_t;

    typedef struct {
        string       name;
        logic [15:0] br;
        logic        dz;
    } done_exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] ctrl;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] to_acc;
    logic [15:0] br_out;
    logic        busy;
    logic        done;
    logic [3:0]  flags;
    logic        dz;

    exp_t        sq[$];
    done_exp_t   dq[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [3:0]  exp_flags;

    alu_seq dut (
        .clk            (clk),
        .rst            (rst),
        .control_signal (ctrl),
        .from_ACC       (a),
        .from_MBR       (b),
        .to_ACC         (to_acc),
        .BR_out         (br_out),
        .busy           (busy),
        .done           (done),
        .flags          (flags),
        .dz             (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pick(int k);
        case (k)
            K_ACC:   return to_acc;
            K_BR:    return br_out;
            K_FLAGS: return {12'd0, flags};
            K_DZ:    return {15'd0, dz};
            K_BUSY:  return {15'd0, busy};
            default: return {15'd0, done};
        endcase
    endfunction

    // Monitor: compare every queued expectation and every done pulse
    always @(negedge clk) begin
        exp_t        e;
        done_exp_t   d;
        logic [15:0] got;
        while (sq.size() > 0) begin
            e   = sq.pop_front();
            got = pick(e.kind);
            n_vec++;
            if (got !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        if (done === 1'b1) begin
            if (dq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected done=0 at %0t", $time);
            end else begin
                d = dq.pop_front();
                n_vec += 2;
                if (br_out !== d.br) begin
                    n_err++;
                    $display("FAIL %s_br: got %h expected %h", d.name, br_out, d.br);
                end
                if (dz !== d.dz) begin
                    n_err++;
                    $display("FAIL %s_dz: got %b expected %b", d.name, dz, d.dz);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string nm, input int k, input logic [15:0] v);
        exp_t e;
        e.name = nm;
        e.kind = k;
        e.val  = v;
        sq.push_back(e);
    endtask

    task automatic comb(input string nm, input logic [31:0] c, input logic [15:0] av,
                        input logic [15:0] bv, input logic [15:0] exp_v);
        ctrl = c;
        a    = av;
        b    = bv;
        expect_val(nm, K_ACC, exp_v);
        tick();
        ctrl = '0;
    endtask

    task automatic run_op(input string nm, input logic [31:0] c, input logic [15:0] av,
                          input logic [15:0] bv, input logic [15:0] exp_lo,
                          input logic [15:0] exp_br, input logic exp_dz,
                          input bit zero_lat, input bit inject);
        done_exp_t d;
        d.name = nm;
        d.br   = exp_br;
        d.dz   = exp_dz;
        dq.push_back(d);
        ctrl = c;
        a    = av;
        b    = bv;
        tick();
        ctrl = '0;
        a    = 16'h5A5A;
        b    = 16'hA5A5;
        if (!zero_lat) begin
            for (int i = 0; i < 16; i++) begin
                ctrl = '0;
                expect_val({nm, "_busy"}, K_BUSY, 16'd1);
                expect_val({nm, "_nodone"}, K_DONE, 16'd0);
                if (i == 0) expect_val({nm, "_dz_clr"}, K_DZ, 16'd0);
                if (inject && i == 3) begin
                    ctrl = (32'd1 << B_MPY) | (32'd1 << B_ADD);
                    a    = 16'h7FFF;
                    b    = 16'h0001;
                    expect_val({nm, "_busy_acc"}, K_ACC, 16'h0000);
                end
                if (inject && i == 4) expect_val({nm, "_busy_flags"}, K_FLAGS, {12'd0, exp_flags});
                tick();
            end
        end
        ctrl = 32'd1 << B_MOV;
        expect_val({nm, "_done"}, K_DONE, 16'd1);
        expect_val({nm, "_done_nobusy"}, K_BUSY, 16'd0);
        expect_val({nm, "_lo"}, K_ACC, exp_lo);
        tick();
        expect_val({nm, "_done_end"}, K_DONE, 16'd0);
        expect_val({nm, "_lo_hold"}, K_ACC, exp_lo);
        expect_val({nm, "_br_hold"}, K_BR, exp_br);
        expect_val({nm, "_dz_hold"}, K_DZ, {15'd0, exp_dz});
        tick();
        ctrl = '0;
    endtask

    initial begin
        rst       = 1'b1;
        ctrl      = '0;
        a         = '0;
        b         = '0;
        exp_flags = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        ctrl = 32'd1 << B_MOV;
        expect_val("rst_busy",  K_BUSY,  16'd0);
        expect_val("rst_done",  K_DONE,  16'd0);
        expect_val("rst_br",    K_BR,    16'd0);
        expect_val("rst_flags", K_FLAGS, 16'd0);
        expect_val("rst_dz",    K_DZ,    16'd0);
        expect_val("rst_mov",   K_ACC,   16'd0);
        tick();
        ctrl = '0;

        // Combinational ops and flags
        comb("add", 32'd1 << B_ADD, 16'h7FFF, 16'h0001, 16'h8000);
        expect_val("add_flags", K_FLAGS, 16'h0005);
        tick();
        comb("sub", 32'd1 << B_SUB, 16'h0000, 16'h0001, 16'hFFFF);
        expect_val("sub_flags", K_FLAGS, 16'h0006);
        tick();
        comb("and",  32'd1 << B_AND, 16'hF0F0, 16'hFF00, 16'hF000);
        comb("or",   32'd1 << B_OR,  16'hF0F0, 16'hFF00, 16'hFFF0);
        comb("not",  32'd1 << B_NOT, 16'hF0F0, 16'hFF00, 16'h0F0F);
        comb("shr",  32'd1 << B_SHR, 16'h8002, 16'h0000, 16'hC001);
        comb("shl",  32'd1 << B_SHL, 16'h8001, 16'h0000, 16'h0002);
        comb("noop", 32'd0,          16'h1234, 16'h4321, 16'h0000);
        expect_val("logic_flags_kept", K_FLAGS, 16'h0006);
        tick();
        comb("prio_add_sub", (32'd1 << B_ADD) | (32'd1 << B_SUB), 16'h0005, 16'h0003, 16'h0008);
        expect_val("prio_flags", K_FLAGS, 16'h0000);
        tick();
        comb("prio_shl_and", (32'd1 << B_SHL) | (32'd1 << B_AND), 16'h0003, 16'h0001, 16'h0006);
        comb("sub_zero", 32'd1 << B_SUB, 16'h0005, 16'h0005, 16'h0000);
        expect_val("zero_flags", K_FLAGS, 16'h0008);
        exp_flags = 4'h8;
        tick();

        // Multi-cycle ops
        run_op("mpy1",    32'd1 << B_MPY, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b0, 1'b0, 1'b0);
        run_op("mpy2",    32'd1 << B_MPY, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op("div1",    32'd1 << B_DIV, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 1'b0);
        run_op("div0",    32'd1 << B_DIV, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b1, 1'b0);
        run_op("mpy_inj", 32'd1 << B_MPY, 16'd3,    16'd5,    16'd15,   16'd0,    1'b0, 1'b0, 1'b1);
        run_op("both",    (32'd1 << B_MPY) | (32'd1 << B_DIV), 16'd6, 16'd7, 16'd42, 16'd0, 1'b0, 1'b0, 1'b0);
        run_op("div2",    32'd1 << B_DIV, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a multiply
        ctrl = 32'd1 << B_MPY;
        a    = 16'h1234;
        b    = 16'h0100;
        tick();
        ctrl = '0;
        repeat (7) tick();
        expect_val("pre_rst_busy", K_BUSY, 16'd1);
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        ctrl = 32'd1 << B_MOV;
        exp_flags = '0;
        expect_val("abort_busy",  K_BUSY,  16'd0);
        expect_val("abort_done",  K_DONE,  16'd0);
        expect_val("abort_br",    K_BR,    16'd0);
        expect_val("abort_mov",   K_ACC,   16'd0);
        expect_val("abort_flags", K_FLAGS, 16'd0);
        tick();
        ctrl = '0;
        for (int i = 0; i < 20; i++) begin
            if (i == 12) expect_val("abort_still_idle", K_BUSY, 16'd0);
            tick();
        end
        run_op("mpy_after_rst", 32'd1 << B_MPY, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0);

        repeat (3) tick();
        while (dq.size() > 0) begin
            done_exp_t d;
            d = dq.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s_missing_done: got no done pulse expected one", d.name);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
